// File: rtl/lh_pkg.sv
// Shared definitions for lh_hash_core: IV, FSM states, byte rotate and the AES S-box.
// The PAD state only exists when LH_LENGTH_PAD_EN is defined.
package lh_pkg;

  typedef logic [7:0] lh_byte_t;

`ifdef LH_LENGTH_PAD_EN
  typedef enum logic [2:0] {IDLE, WAIT, RUN, DONE, PAD} lh_state_e;
`else
  typedef enum logic [2:0] {IDLE, WAIT, RUN, DONE} lh_state_e;
`endif

  localparam lh_byte_t LH_IV [0:15] = '{
    8'h34, 8'h55, 8'h0F, 8'h14, 8'hDA, 8'hC0, 8'h2B, 8'hEE,
    8'h6A, 8'h91, 8'hC7, 8'h3D, 8'h58, 8'hE2, 8'hB4, 8'h07
  };

  localparam lh_byte_t LH_SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic lh_byte_t rotl8(input lh_byte_t b, input logic [2:0] amt);
    logic [15:0] w_wide;
    w_wide = {b, b} << amt;
    return w_wide[15:8];
  endfunction

  function automatic lh_byte_t aes128_sbox(input lh_byte_t x);
    return LH_SBOX[x];
  endfunction

endpackage

// File: rtl/lh_round.sv
// lh_round: one combinational hash round; every output byte is derived from the old state and m.
module lh_round
  import lh_pkg::*;
#(
  parameter int DIGEST_BYTES = 8
) (
  input  logic [DIGEST_BYTES*8-1:0] i_h,
  input  logic [7:0]                i_m,
  output logic [DIGEST_BYTES*8-1:0] o_h
);

  for (genvar j = 0; j < DIGEST_BYTES; j++) begin : g_byte
    localparam int         SRC = (j + 2) % DIGEST_BYTES;
    localparam logic [2:0] AMT = 3'(j % 8);
    lh_byte_t w_t;
    assign w_t = i_h[SRC*8 +: 8] ^ i_m;
    assign o_h[j*8 +: 8] = aes128_sbox(rotl8(w_t, AMT));
  end

endmodule

// File: rtl/lh_hash_core.sv
// lh_hash_core: handshaked byte-stream hash, ROUNDS_PER_CYCLE chained lh_round stages per clock.
// Defining LH_LENGTH_PAD_EN appends the 8-bit message length as a final absorbed byte.
module lh_hash_core
  import lh_pkg::*;
#(
  parameter int DIGEST_BYTES     = 8,
  parameter int ROUNDS           = 32,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGEST_BYTES*8-1:0] digest
);

  localparam int CYCLES = ROUNDS / ROUNDS_PER_CYCLE;
  localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CYCLES - 1);

  typedef lh_byte_t [DIGEST_BYTES-1:0] lh_digest_t;

  lh_state_e  r_state, w_nextState;
  logic [CW-1:0] r_cnt, w_nextCnt;
  lh_byte_t   r_m, w_nextM;
  logic       r_last, w_nextLast;
  lh_digest_t r_h, w_nextH, r_dig, w_nextDig, w_iv, w_roundOut;
  logic       w_roundsDone;
`ifdef LH_LENGTH_PAD_EN
  lh_byte_t   r_len, w_nextLen;
`endif

  for (genvar j = 0; j < DIGEST_BYTES; j++) begin : g_iv
    assign w_iv[j] = LH_IV[j];
  end

  // Separate per-stage nets keep the unrolled chain free of self-referencing vectors.
  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
    lh_digest_t w_hIn, w_hOut;
    if (k == 0) begin : g_head
      assign w_hIn = r_h;
    end else begin : g_link
      assign w_hIn = g_round[k-1].w_hOut;
    end
    lh_round #(.DIGEST_BYTES(DIGEST_BYTES)) u_round (
      .i_h(w_hIn),
      .i_m(r_m),
      .o_h(w_hOut)
    );
  end

  assign w_roundOut   = g_round[ROUNDS_PER_CYCLE-1].w_hOut;
  assign w_roundsDone = (r_cnt == LAST_CNT);
  assign digest       = r_dig;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextM     = r_m;
    w_nextLast  = r_last;
    w_nextH     = r_h;
    w_nextDig   = r_dig;
`ifdef LH_LENGTH_PAD_EN
    w_nextLen   = r_len;
`endif
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_first) begin
          w_nextH     = w_iv;
          w_nextM     = in_data;
          w_nextLast  = in_last;
          w_nextCnt   = '0;
          w_nextState = RUN;
`ifdef LH_LENGTH_PAD_EN
          w_nextLen   = 8'd1;
`endif
        end
      end
      WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_first) w_nextH = w_iv;
          w_nextM     = in_data;
          w_nextLast  = in_last;
          w_nextCnt   = '0;
          w_nextState = RUN;
`ifdef LH_LENGTH_PAD_EN
          w_nextLen   = in_first ? 8'd1 : r_len + 8'd1;
`endif
        end
      end
      RUN: begin
        w_nextH   = w_roundOut;
        w_nextCnt = r_cnt + 1'b1;
        if (w_roundsDone) begin
          w_nextCnt = '0;
          if (!r_last) begin
            w_nextState = WAIT;
          end else begin
`ifdef LH_LENGTH_PAD_EN
            w_nextState = PAD;
            w_nextM     = r_len;
`else
            w_nextState = DONE;
            w_nextDig   = w_roundOut;
`endif
          end
        end
      end
`ifdef LH_LENGTH_PAD_EN
      PAD: begin
        w_nextH   = w_roundOut;
        w_nextCnt = r_cnt + 1'b1;
        if (w_roundsDone) begin
          w_nextCnt   = '0;
          w_nextState = DONE;
          w_nextDig   = w_roundOut;
        end
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
          w_nextH     = w_iv;
          w_nextDig   = '0;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_m     <= '0;
      r_last  <= 1'b0;
      r_h     <= w_iv;
      r_dig   <= '0;
`ifdef LH_LENGTH_PAD_EN
      r_len   <= '0;
`endif
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_m     <= w_nextM;
      r_last  <= w_nextLast;
      r_h     <= w_nextH;
      r_dig   <= w_nextDig;
`ifdef LH_LENGTH_PAD_EN
      r_len   <= w_nextLen;
`endif
    end
  end

endmodule

// File: tb/tb_lh_hash_core.sv
// tb_lh_hash_core: scoreboard bench for lh_hash_core, default instance plus two parameter-sweep instances.
// The reference model derives the S-box from GF(2^8) arithmetic and honours LH_LENGTH_PAD_EN.
module tb_lh_hash_core;

  logic clk = 1'b0;
  logic rst, inValid, inFirst, inLast, outReady, sweepValid, sweepReady;
  logic [7:0] inData;
  logic inReady, outValid, readyB, validB, readyC, validC;
  logic [63:0]  digestA;
  logic [127:0] digestB;
  logic [31:0]  digestC;

  int checks = 0;
  int errors = 0;

  logic [7:0]   modelSbox [256];
  logic [7:0]   msgQ [$];
  logic [127:0] expQ [$];

`ifdef LH_LENGTH_PAD_EN
  localparam int PAD_MSG = 1;
`else
  localparam int PAD_MSG = 0;
`endif
  localparam int LAT = 32 * (1 + PAD_MSG);

  localparam logic [7:0] IV_REF [16] = '{
    8'h34, 8'h55, 8'h0F, 8'h14, 8'hDA, 8'hC0, 8'h2B, 8'hEE,
    8'h6A, 8'h91, 8'hC7, 8'h3D, 8'h58, 8'hE2, 8'hB4, 8'h07
  };

  always #5 clk = ~clk;

  lh_hash_core dutA (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .in_first(inFirst), .in_last(inLast), .out_valid(outValid), .out_ready(outReady), .digest(digestA)
  );

  lh_hash_core #(.DIGEST_BYTES(16), .ROUNDS(32), .ROUNDS_PER_CYCLE(4)) dutB (
    .clk(clk), .rst(rst), .in_valid(sweepValid), .in_ready(readyB), .in_data(inData),
    .in_first(inFirst), .in_last(inLast), .out_valid(validB), .out_ready(sweepReady), .digest(digestB)
  );

  lh_hash_core #(.DIGEST_BYTES(4), .ROUNDS(32), .ROUNDS_PER_CYCLE(2)) dutC (
    .clk(clk), .rst(rst), .in_valid(sweepValid), .in_ready(readyC), .in_data(inData),
    .in_first(inFirst), .in_last(inLast), .out_valid(validC), .out_ready(sweepReady), .digest(digestC)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotlRef(input logic [7:0] v, input int a);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < a; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Digest of msgQ (plus the length byte when padding is built in) for an n-byte state.
  function automatic logic [127:0] modelDigest(input int n);
    logic [7:0] h [16];
    logic [7:0] nh [16];
    logic [7:0] m, t;
    logic [127:0] r;
    int total;
    for (int j = 0; j < 16; j++) begin h[j] = IV_REF[j]; nh[j] = 8'h00; end
    total = msgQ.size();
    for (int i = 0; i < total + PAD_MSG; i++) begin
      m = (i < total) ? msgQ[i] : 8'(total);
      for (int rd = 0; rd < 32; rd++) begin
        for (int j = 0; j < n; j++) begin
          t = h[(j + 2) % n] ^ m;
          t = rotlRef(t, j % 8);
          nh[j] = modelSbox[t];
        end
        for (int j = 0; j < n; j++) h[j] = nh[j];
      end
    end
    r = '0;
    for (int j = 0; j < n; j++) r[j*8 +: 8] = h[j];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one byte on the main port and returns at the negedge after it is accepted.
  task automatic applyStimulus(input logic [7:0] d, input logic f, input logic l, input int gap);
    int waitN;
    repeat (gap) @(negedge clk);
    inData = d; inFirst = f; inLast = l; inValid = 1'b1;
    waitN = 0;
    while (!inReady && waitN < 300) begin @(negedge clk); waitN++; end
    if (!inReady) checkOutput("acceptTimeout", 128'(0), 128'(1));
    @(posedge clk);
    if (f) msgQ.delete();
    msgQ.push_back(d);
    @(negedge clk);
    inValid = 1'b0; inFirst = 1'b0; inLast = 1'b0;
  endtask

  task automatic checkBusy(input string tag);
    int n;
    n = 0;
    while (!inReady && n < 300) begin @(negedge clk); n++; end
    checkOutput(tag, 128'(n), 128'(32));
  endtask

  task automatic awaitDigest(input string tag, input int expLat, input int hold);
    int lat;
    logic [127:0] expected;
    lat = 0;
    while (!outValid && lat < 300) begin @(posedge clk); lat++; @(negedge clk); end
    checkOutput({tag, "Latency"}, 128'(lat), 128'(expLat));
    expected = (expQ.size() > 0) ? expQ.pop_front() : '1;
    checkOutput({tag, "Digest"}, 128'(digestA), expected);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, "Hold"}, {127'(0), outValid, 64'(0)} | 128'(digestA), {127'(1), 64'(0)} | expected);
    end
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    checkOutput({tag, "ClearValid"}, 128'(outValid), 128'(0));
    checkOutput({tag, "ClearDigest"}, 128'(digestA), 128'(0));
  endtask

  initial begin
    int seen, latB, latC;
    logic [7:0] inv, s;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotlRef(inv, 1) ^ rotlRef(inv, 2) ^ rotlRef(inv, 3) ^ rotlRef(inv, 4) ^ 8'h63;
      modelSbox[x] = s;
    end

    rst = 1'b1; inValid = 1'b0; inFirst = 1'b0; inLast = 1'b0; inData = 8'h00;
    outReady = 1'b0; sweepValid = 1'b0; sweepReady = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("resetValid", 128'(outValid), 128'(0));
    checkOutput("resetDigest", 128'(digestA), 128'(0));
    checkOutput("resetReady", 128'(inReady), 128'(1));

    $display("[TB] one-byte message 0x00");
    applyStimulus(8'h00, 1'b1, 1'b1, 0);
    expQ.push_back(modelDigest(8));
    awaitDigest("oneByte", LAT, 10);

    $display("[TB] message abc with gaps");
    applyStimulus(8'h61, 1'b1, 1'b0, $urandom_range(0, 3));
    checkBusy("abcBusy0");
    applyStimulus(8'h62, 1'b0, 1'b0, $urandom_range(0, 3));
    checkBusy("abcBusy1");
    applyStimulus(8'h63, 1'b0, 1'b1, $urandom_range(0, 3));
    expQ.push_back(modelDigest(8));
    awaitDigest("abc", LAT, 0);

    $display("[TB] reset during rounds");
    applyStimulus(8'h55, 1'b1, 1'b1, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (outValid) seen++;
      @(negedge clk);
    end
    checkOutput("resetRunNoValid", 128'(seen), 128'(0));
    checkOutput("resetRunReady", 128'(inReady), 128'(1));

    $display("[TB] dropped byte then restart");
    applyStimulus(8'h99, 1'b0, 1'b0, 0);
    checkOutput("dropStaysIdle", 128'(inReady), 128'(1));
    applyStimulus(8'h11, 1'b1, 1'b0, 0);
    checkBusy("restartBusy0");
    applyStimulus(8'h22, 1'b0, 1'b0, 1);
    checkBusy("restartBusy1");
    applyStimulus(8'h33, 1'b1, 1'b1, 0);
    expQ.push_back(modelDigest(8));
    awaitDigest("restart", LAT, 0);

    $display("[TB] parameter sweep instances");
    checkOutput("sweepReadyB", 128'(readyB), 128'(1));
    checkOutput("sweepReadyC", 128'(readyC), 128'(1));
    inData = 8'h33; inFirst = 1'b1; inLast = 1'b1; sweepValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sweepValid = 1'b0; inFirst = 1'b0; inLast = 1'b0;
    msgQ.delete();
    msgQ.push_back(8'h33);
    latB = -1; latC = -1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (validB && latB < 0) latB = n;
      if (validC && latC < 0) latC = n;
    end
    checkOutput("sweepLatencyB", 128'(latB), 128'(8 * (1 + PAD_MSG)));
    checkOutput("sweepLatencyC", 128'(latC), 128'(16 * (1 + PAD_MSG)));
    checkOutput("sweepDigestB", digestB, modelDigest(16));
    checkOutput("sweepDigestC", 128'(digestC), modelDigest(4));
    sweepReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sweepReady = 1'b0;
    checkOutput("sweepClearB", 128'(validB), 128'(0));
    checkOutput("sweepClearC", 128'(digestC), 128'(0));

    $display("[TB] 300-byte message");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'($urandom), (i == 0), (i == 299), 0);
      if (i == 299) expQ.push_back(modelDigest(8));
    end
    awaitDigest("long", LAT, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
